// File: rtl/pwm_fade_sequencer_if.sv
// Config write port of pwm_fade_sequencer: one valid/ready write of (channel, mode, duty).
interface pwm_fade_sequencer_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 8
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic            cfg_valid;
    logic            cfg_ready;
    logic [CH_W-1:0] cfg_ch;
    logic            cfg_mode;
    logic [CNT_W-1:0] cfg_duty;

    modport master (output cfg_valid, cfg_ch, cfg_mode, cfg_duty, input cfg_ready);
    modport slave  (input cfg_valid, cfg_ch, cfg_mode, cfg_duty, output cfg_ready);
endinterface

// File: rtl/pwm_fade_sequencer.sv
// Shared-counter multi-channel PWM with boundary-synchronous config and triangle breathing ramps.
// Optional phase-staggered channel compare under `define PWM_PHASE_STAGGER_EN.
module pwm_fade_sequencer #(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned PERIOD       = 100,
    parameter int unsigned STEP_PERIODS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    pwm_fade_sequencer_if.slave  cfg,
    output logic [NUM_CH-1:0]    led,
    output logic                 period_tick
);
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned STEP_W = $clog2(STEP_PERIODS + 1);
    localparam logic [CNT_W-1:0] TOP  = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(PERIOD + 1);

    typedef enum logic {RAMP_UP, RAMP_DOWN} ramp_e;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  duty_q [NUM_CH];
    logic [CNT_W-1:0]  duty_d [NUM_CH];
    logic [CNT_W-1:0]  peak_q [NUM_CH];
    logic [CNT_W-1:0]  peak_d [NUM_CH];
    ramp_e             dir_q  [NUM_CH];
    ramp_e             dir_d  [NUM_CH];
    logic [NUM_CH-1:0] mode_q, mode_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              pend_q, pend_d;
    logic [CH_W-1:0]   pch_q, pch_d;
    logic              pmode_q, pmode_d;
    logic [CNT_W-1:0]  pduty_q, pduty_d;

    logic             wrap, bnd, step_fire, accept;
    logic [CNT_W-1:0] clamped;

    assign wrap          = enable && (cnt_q == TOP);
    assign bnd           = wrap || !enable;
    assign step_fire     = wrap && (step_q == STEP_W'(STEP_PERIODS - 1));
    assign cfg.cfg_ready = !pend_q && !rst;
    assign accept        = cfg.cfg_valid && cfg.cfg_ready;
    assign clamped       = (cfg.cfg_duty > FULL) ? FULL : cfg.cfg_duty;
    assign period_tick   = !rst && wrap;

    always_comb begin
        cnt_d   = '0;
        step_d  = step_q;
        pend_d  = pend_q;
        pch_d   = pch_q;
        pmode_d = pmode_q;
        pduty_d = pduty_q;
        mode_d  = mode_q;

        if (enable) begin
            cnt_d = (cnt_q == TOP) ? '0 : cnt_q + 1'b1;
        end
        if (wrap) begin
            step_d = step_fire ? '0 : step_q + 1'b1;
        end

        if (accept) begin
            pend_d  = 1'b1;
            pch_d   = cfg.cfg_ch;
            pmode_d = cfg.cfg_mode;
            pduty_d = clamped;
        end else if (bnd && pend_q) begin
            pend_d = 1'b0;
        end

        for (int unsigned i = 0; i < NUM_CH; i++) begin
            duty_d[i] = duty_q[i];
            peak_d[i] = peak_q[i];
            dir_d[i]  = dir_q[i];
            // A pending write to this channel pre-empts its ramp step on the same boundary.
            if (bnd && pend_q && (pch_q == CH_W'(i))) begin
                mode_d[i] = pmode_q;
                if (pmode_q) begin
                    peak_d[i] = pduty_q;
                    duty_d[i] = '0;
                    dir_d[i]  = RAMP_UP;
                end else begin
                    duty_d[i] = pduty_q;
                end
            end else if (step_fire && mode_q[i] && (peak_q[i] != '0)) begin
                case (dir_q[i])
                    RAMP_UP: begin
                        if (duty_q[i] == peak_q[i]) begin
                            dir_d[i]  = RAMP_DOWN;
                            duty_d[i] = duty_q[i] - 1'b1;
                        end else begin
                            duty_d[i] = duty_q[i] + 1'b1;
                        end
                    end
                    default: begin
                        if (duty_q[i] == '0) begin
                            dir_d[i]  = RAMP_UP;
                            duty_d[i] = duty_q[i] + 1'b1;
                        end else begin
                            duty_d[i] = duty_q[i] - 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            mode_q  <= '0;
            step_q  <= '0;
            pend_q  <= 1'b0;
            pch_q   <= '0;
            pmode_q <= 1'b0;
            pduty_q <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                duty_q[i] <= '0;
                peak_q[i] <= '0;
                dir_q[i]  <= RAMP_UP;
            end
        end else begin
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            step_q  <= step_d;
            pend_q  <= pend_d;
            pch_q   <= pch_d;
            pmode_q <= pmode_d;
            pduty_q <= pduty_d;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                duty_q[i] <= duty_d[i];
                peak_q[i] <= peak_d[i];
                dir_q[i]  <= dir_d[i];
            end
        end
    end

`ifdef PWM_PHASE_STAGGER_EN
    localparam int unsigned OFF = (PERIOD + 1) / NUM_CH;
    logic [CNT_W:0] phase;

    always_comb begin
        led   = '0;
        phase = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            phase = {1'b0, cnt_q} + (CNT_W+1)'(i * OFF);
            if (phase >= (CNT_W+1)'(PERIOD + 1)) begin
                phase = phase - (CNT_W+1)'(PERIOD + 1);
            end
            led[i] = !rst && enable && (phase[CNT_W-1:0] < duty_q[i]);
        end
    end
`else
    always_comb begin
        led = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            led[i] = !rst && enable && (cnt_q < duty_q[i]);
        end
    end
`endif

endmodule

// File: doc/pwm_fade_sequencer.md
Name: pwm_fade_sequencer

Overview:
Controller for the shared-counter multi-channel LED PWM datapath. Owns the period counter and per-channel duty registers. Accepts duty/mode writes over a valid/ready config port and applies them glitch-free only at period boundaries. Optionally runs a per-channel triangle "breathing" ramp, so LED brightness sequences without software involvement.

Parameters:
NUM_CH, 4, number of PWM channels (cfg_ch width = clog2(NUM_CH))
CNT_W, 8, period counter and duty width; PERIOD+1 must be < 2**CNT_W
PERIOD, 100, terminal count; one PWM period = PERIOD+1 clk cycles
STEP_PERIODS, 4, PWM periods between breathing duty steps (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
enable  in  1  run PWM; low forces leds off and holds counter at 0
cfg_valid  in  1  config write request
cfg_ready  out  1  config write can be accepted (= !pending && !rst)
cfg_ch  in  clog2(NUM_CH)  target channel
cfg_mode  in  1  0 = static duty, 1 = breathe (cfg_duty is the peak)
cfg_duty  in  CNT_W  duty in counts (0..PERIOD+1)
led  out  NUM_CH  PWM outputs
period_tick  out  1  1-cycle pulse on the cycle counter==PERIOD (enable high)

Behaviour:
- Reset: counter=0, all duty_active=0, all modes static, ramp state UP, step counter 0, pending=0; led=0, period_tick=0, cfg_ready=0 while rst high.
- Counter: if enable, counter<=(counter==PERIOD)?0:counter+1; else counter<=0.
- led[i] = enable && (counter < duty_active[i]), combinational from registers. duty 0 = always low; duty PERIOD+1 = always high.
- Boundary event B = (enable && counter==PERIOD) || !enable. duty_active, mode and ramp state change only on B.
- Handshake: write accepted when cfg_valid && cfg_ready; captured into a single pending slot (ch, mode, duty); cfg_ready drops the next cycle. On the next B, pending is applied and cleared; cfg_ready rises the cycle after. A write accepted on the B cycle itself is not applied on that B; it waits for the following one.
- Duty clamp: cfg_duty > PERIOD+1 is stored as PERIOD+1.
- Apply static: duty_active[ch]=clamped duty.
- Apply breathe: peak[ch]=clamped duty, duty_active[ch]=0, state UP. This restarts the ramp.
- Breathe step: step counter increments on each enabled wrap. Every STEP_PERIODS wraps, a step event fires coincident with B. For each breathing channel:
  - UP: if duty==peak, go to DOWN and decrement; else increment.
  - DOWN: if duty==0, go to UP and increment; else decrement.
  - peak==0: duty stays 0, no state change.
  - Resulting sequence for peak P: 0,1..P,P-1..0,1,…
- Simultaneous pending apply and step on the same channel: the config write wins, and no step is applied to that channel this boundary.
- enable low: counter held 0, led=0, step counter and ramps frozen, pending applied on the next cycle.
- rst mid-period or mid-handshake: all state returns to reset values; the pending write is discarded.

Optional Feature:
PWM_PHASE_STAGGER_EN
- Defined: channel i compares ((counter + i*OFF) mod (PERIOD+1)) < duty_active[i], with OFF = (PERIOD+1)/NUM_CH (integer division; 25 for defaults). Channels turn on staggered, reducing supply current peaks. Duty ratios are unchanged. Boundary timing, period_tick and the handshake are unchanged.
- Undefined: all channels compare the raw counter, so every channel with nonzero duty rises on counter==0.

Test Plan:
- Reset, enable=1, write ch0 static duty 20 -> after next wrap, led[0] high exactly 20 of every 101 cycles; period_tick every 101 cycles.
- Write ch1 duty 40 at counter=50 -> cfg_ready low from the next cycle until the cycle after counter==100; old duty is kept for the rest of the current period; new duty starts at counter==0.
- Write accepted on the cycle counter==100 -> not applied at that wrap; applied at the following wrap, 101 cycles later.
- ch2 breathe peak 3, STEP_PERIODS=4 -> duty_active sequence 0,1,2,3,2,1,0,1, each value lasting 4 periods (404 cycles).
- Write duty 200 to ch3 -> clamps to 101, led[3] constantly high. Write duty 0 -> led[3] constantly low.
- Assert rst for 1 cycle mid-ramp with a write pending -> led=0 and cfg_ready=0 during rst; after rst, all duties are 0 and the pending write is lost. Drop enable -> led=0 next cycle and counter holds at 0.
